backprop_sequencer: RTL and testbench

Control-sequencing stage that sits directly upstream of the backprop diff pipeline register. It walks the network backwards, from the cost layer down to layer 0, one weight row per cycle. For each row it issues `w_layer_index`, `w_row_index`, `backprop_cost`, `is_update` and `is_cost_layer`, which the downstream register stage then carries alongside the diff vectors. It supports a start/done handshake, a downstream stall, and skipping of empty layers.

---
 rtl/backprop_seq_pkg.sv | 37 +++
 rtl/backprop_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_backprop_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/backprop_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : backprop_seq_pkg
//  Description : Shared types, constants and helpers for backprop_sequencer.
//                Provides the sequencer state encoding, the index output
//                width, and a field extractor for the packed row-count bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package backprop_seq_pkg;

    // Width of the layer/row index outputs.
    localparam int INDEX_W     = 32;

    // Widest row-count bus row_count() can accept. Callers zero-extend
    // their bus to this width before calling.
    localparam int ROW_BUS_MAX = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    // Returns field i (width w) of a packed count bus, zero-extended to
    // INDEX_W bits. Field widths beyond INDEX_W are truncated.
    function automatic logic [INDEX_W-1:0] row_count(
        input logic [ROW_BUS_MAX-1:0] bus,
        input logic [INDEX_W-1:0]     i,
        input logic [INDEX_W-1:0]     w
    );
        logic [INDEX_W-1:0] mask;
        mask = (w >= INDEX_W) ? '1 : ((INDEX_W'(1) << w) - INDEX_W'(1));
        return INDEX_W'(bus >> (i * w)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/backprop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : backprop_sequencer
//  Description : Walks the network backwards from the cost layer to layer 0,
//                issuing one (layer,row) beat per unstalled cycle for the
//                backprop diff pipeline. Zero-row layers cost one skip cycle.
//                All outputs are registered.
//  Ports       : clk, rst_n (sync, active-low)
//                start / update_en     - pass request and update mode
//                stall                 - downstream not ready
//                layer_row_count       - packed per-layer row counts
//                busy / done           - pass status, done is a 1-cycle pulse
//                valid, w_layer_index, w_row_index,
//                backprop_cost, is_update, is_cost_layer - beat outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module backprop_sequencer
    import backprop_seq_pkg::*;
#(
    parameter int LAYER_COUNT = 3,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               update_en,
    input  logic                               stall,
    input  logic [LAYER_COUNT*COUNT_WIDTH-1:0] layer_row_count,
    output logic                               busy,
    output logic                               done,
    output logic                               valid,
    output logic [INDEX_W-1:0]                 w_layer_index,
    output logic [INDEX_W-1:0]                 w_row_index,
    output logic                               backprop_cost,
    output logic                               is_update,
    output logic                               is_cost_layer
);

    localparam int LW    = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
    localparam int BUS_W = LAYER_COUNT * COUNT_WIDTH;

    localparam logic [LW-1:0] c_last_layer = LW'(LAYER_COUNT - 1);

    // Pass state, counters and the values captured at start.
    seq_state_t             r_state;
    logic [LW-1:0]          r_layer;
    logic [COUNT_WIDTH-1:0] r_row;
    logic [BUS_W-1:0]       r_counts;
    logic                   r_update;

    // Next-state values for every register, outputs included.
    seq_state_t             w_state_nxt;
    logic [LW-1:0]          w_layer_nxt;
    logic [COUNT_WIDTH-1:0] w_row_nxt;
    logic [BUS_W-1:0]       w_counts_nxt;
    logic                   w_update_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_valid_nxt;
    logic [INDEX_W-1:0]     w_layer_index_nxt;
    logic [INDEX_W-1:0]     w_row_index_nxt;
    logic                   w_backprop_cost_nxt;
    logic                   w_is_update_nxt;
    logic                   w_is_cost_layer_nxt;

    logic [INDEX_W-1:0]     w_cur_count;
    logic                   w_last_row;
    logic                   w_at_cost_layer;

    // Row count of the layer currently being walked, from the captured copy
    // so mid-pass changes on the input bus have no effect.
    assign w_cur_count     = row_count(ROW_BUS_MAX'(r_counts),
                                       INDEX_W'(r_layer),
                                       INDEX_W'(COUNT_WIDTH));
    // Compared at full index width so a count of 2**COUNT_WIDTH-1 ends on
    // the last representable row without the row counter ever wrapping.
    assign w_last_row      = (INDEX_W'(r_row) == (w_cur_count - INDEX_W'(1)));
    assign w_at_cost_layer = (r_layer == c_last_layer);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_layer       <= '0;
            r_row         <= '0;
            r_counts      <= '0;
            r_update      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            w_layer_index <= '0;
            w_row_index   <= '0;
            backprop_cost <= 1'b0;
            is_update     <= 1'b0;
            is_cost_layer <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_layer       <= w_layer_nxt;
            r_row         <= w_row_nxt;
            r_counts      <= w_counts_nxt;
            r_update      <= w_update_nxt;
            busy          <= w_busy_nxt;
            done          <= w_done_nxt;
            valid         <= w_valid_nxt;
            w_layer_index <= w_layer_index_nxt;
            w_row_index   <= w_row_index_nxt;
            backprop_cost <= w_backprop_cost_nxt;
            is_update     <= w_is_update_nxt;
            is_cost_layer <= w_is_cost_layer_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_layer_nxt         = r_layer;
        w_row_nxt           = r_row;
        w_counts_nxt        = r_counts;
        w_update_nxt        = r_update;
        w_busy_nxt          = 1'b0;
        w_done_nxt          = 1'b0;
        w_valid_nxt         = 1'b0;
        // Index outputs only move on a beat; stalls and skips hold them.
        w_layer_index_nxt   = w_layer_index;
        w_row_index_nxt     = w_row_index;
        w_backprop_cost_nxt = 1'b0;
        w_is_update_nxt     = 1'b0;
        w_is_cost_layer_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt  = ISSUE;
                    w_counts_nxt = layer_row_count;
                    w_update_nxt = update_en;
                    w_layer_nxt  = c_last_layer;
                    w_row_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                end
            end

            ISSUE: begin
                // busy stays up through the edge that registers the final
                // beat; it drops together with the done pulse.
                w_busy_nxt = 1'b1;
                if (!stall) begin
                    if (w_cur_count == '0) begin
                        // Empty layer: one skip cycle, no beat.
                        if (r_layer == '0) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_layer_nxt = r_layer - LW'(1);
                            w_row_nxt   = '0;
                        end
                    end else begin
                        w_valid_nxt         = 1'b1;
                        w_layer_index_nxt   = INDEX_W'(r_layer);
                        w_row_index_nxt     = INDEX_W'(r_row);
                        w_is_cost_layer_nxt = w_at_cost_layer;
                        w_backprop_cost_nxt = w_at_cost_layer && (r_row == '0);
                        w_is_update_nxt     = r_update;
                        if (w_last_row) begin
                            if (r_layer == '0) begin
                                w_state_nxt = DONE;
                            end else begin
                                w_layer_nxt = r_layer - LW'(1);
                                w_row_nxt   = '0;
                            end
                        end else begin
                            w_row_nxt = r_row + COUNT_WIDTH'(1);
                        end
                    end
                end
            end

            DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_backprop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_backprop_sequencer
//  Description : Scoreboard bench for backprop_sequencer. Stimulus pushes the
//                hand-derived beat/done sequence (with the edge number each
//                is due on) into a queue; a monitor pops and compares on
//                every cycle the DUT shows valid or done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_backprop_sequencer;

    localparam int LC = 3;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            update_en;
    logic            stall;
    logic [LC*CW-1:0] layer_row_count;
    logic            busy;
    logic            done;
    logic            valid;
    logic [31:0]     w_layer_index;
    logic [31:0]     w_row_index;
    logic            backprop_cost;
    logic            is_update;
    logic            is_cost_layer;

    backprop_sequencer #(
        .LAYER_COUNT (LC),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .update_en       (update_en),
        .stall           (stall),
        .layer_row_count (layer_row_count),
        .busy            (busy),
        .done            (done),
        .valid           (valid),
        .w_layer_index   (w_layer_index),
        .w_row_index     (w_row_index),
        .backprop_cost   (backprop_cost),
        .is_update       (is_update),
        .is_cost_layer   (is_cost_layer)
    );

    always #5 clk = ~clk;

    // Edge counter: value n is visible after the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [31:0] layer;
        logic [31:0] row;
        logic        cost;
        logic        upd;
        logic        cl;
        int          edge_no;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, got, req, cyc);
        end
    endtask

    task automatic exp_beat(input int layer, input int row, input logic upd, input int edge_no);
        exp_t e;
        e.is_done = 1'b0;
        e.layer   = 32'(layer);
        e.row     = 32'(row);
        e.cl      = (layer == LC - 1);
        e.cost    = (layer == LC - 1) && (row == 0);
        e.upd     = upd;
        e.edge_no = edge_no;
        q.push_back(e);
    endtask

    task automatic exp_done(input int edge_no);
        exp_t e;
        e.is_done = 1'b1;
        e.layer   = '0;
        e.row     = '0;
        e.cl      = 1'b0;
        e.cost    = 1'b0;
        e.upd     = 1'b0;
        e.edge_no = edge_no;
        q.push_back(e);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (valid || done) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: edge %0d valid=%0b done=%0b L%0d R%0d, required nothing",
                         cyc, valid, done, w_layer_index, w_row_index);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_done) begin
                    if (!done || valid || busy || cyc != e.edge_no) begin
                        n_bad++;
                        $display("FAIL done_pulse: edge %0d done=%0b valid=%0b busy=%0b, required done at edge %0d with valid=0 busy=0",
                                 cyc, done, valid, busy, e.edge_no);
                    end
                end else begin
                    if (!valid || done || !busy || cyc != e.edge_no ||
                        w_layer_index !== e.layer || w_row_index !== e.row ||
                        backprop_cost !== e.cost || is_update !== e.upd ||
                        is_cost_layer !== e.cl) begin
                        n_bad++;
                        $display("FAIL beat: edge %0d v=%0b d=%0b b=%0b L%0d R%0d cost=%0b upd=%0b cl=%0b, required edge %0d L%0d R%0d cost=%0b upd=%0b cl=%0b",
                                 cyc, valid, done, busy, w_layer_index, w_row_index,
                                 backprop_cost, is_update, is_cost_layer,
                                 e.edge_no, e.layer, e.row, e.cost, e.upd, e.cl);
                    end
                end
            end
        end else if (rst_n) begin
            n_cmp++;
            if (backprop_cost || is_update || is_cost_layer) begin
                n_bad++;
                $display("FAIL idle_flags: edge %0d cost=%0b upd=%0b cl=%0b, required all 0",
                         cyc, backprop_cost, is_update, is_cost_layer);
            end
        end
    end

    // Drives start for one edge; k is the edge that accepts it.
    task automatic do_start(input logic [LC*CW-1:0] counts, input logic upd, output int k);
        @(negedge clk);
        layer_row_count = counts;
        update_en       = upd;
        start           = 1'b1;
        k               = cyc + 1;
        @(negedge clk);
        start           = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // {L2, L1, L0}
    localparam logic [LC*CW-1:0] BASIC = {8'd3, 8'd0, 8'd2};

    task automatic exp_basic(input int k, input logic upd);
        exp_beat(2, 0, upd, k + 1);
        exp_beat(2, 1, upd, k + 2);
        exp_beat(2, 2, upd, k + 3);
        // skip for L1 on edge k+4
        exp_beat(0, 0, upd, k + 5);
        exp_beat(0, 1, upd, k + 6);
        exp_done(k + 7);
    endtask

    initial begin
        int k;
        rst_n           = 1'b0;
        start           = 1'b0;
        update_en       = 1'b0;
        stall           = 1'b0;
        layer_row_count = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_valid",  32'(valid), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_layer",  w_layer_index, 32'd0);
        check("rst_row",    w_row_index, 32'd0);
        check("rst_flags",  32'({backprop_cost, is_update, is_cost_layer}), 32'd0);
        rst_n = 1'b1;

        // Basic pass.
        do_start(BASIC, 1'b1, k);
        check("busy_after_start", 32'(busy), 32'd1);
        exp_basic(k, 1'b1);
        wait_done(20, "basic_done_timeout");

        // Stall for two edges after beat (2,1).
        do_start(BASIC, 1'b1, k);
        exp_beat(2, 0, 1'b1, k + 1);
        exp_beat(2, 1, 1'b1, k + 2);
        exp_beat(2, 2, 1'b1, k + 5);
        exp_beat(0, 0, 1'b1, k + 7);
        exp_beat(0, 1, 1'b1, k + 8);
        exp_done(k + 9);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        check("stall_hold_row", w_row_index, 32'd1);
        @(negedge clk);
        stall = 1'b0;
        wait_done(20, "stall_done_timeout");

        // All layers empty.
        do_start('0, 1'b1, k);
        exp_done(k + 4);
        wait_done(20, "zero_done_timeout");

        // start with stall held in IDLE; issue waits for stall to drop.
        stall = 1'b1;
        do_start({8'd1, 8'd0, 8'd0}, 1'b0, k);
        exp_beat(2, 0, 1'b0, k + 3);
        exp_done(k + 6);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0;
        wait_done(20, "stallstart_done_timeout");

        // Reset during beat (2,1).
        do_start(BASIC, 1'b1, k);
        exp_beat(2, 0, 1'b1, k + 1);
        exp_beat(2, 1, 1'b1, k + 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_done",  32'(done), 32'd0);
        check("midrst_idx",   w_layer_index | w_row_index, 32'd0);
        check("midrst_flags", 32'({backprop_cost, is_update, is_cost_layer}), 32'd0);
        check("midrst_queue", 32'(q.size()), 32'd0);
        rst_n = 1'b1;
        do_start(BASIC, 1'b1, k);
        exp_basic(k, 1'b1);
        wait_done(20, "restart_done_timeout");

        // start, count and update_en changes while busy are ignored.
        do_start(BASIC, 1'b0, k);
        exp_basic(k, 1'b0);
        start           = 1'b1;
        layer_row_count = {8'd1, 8'd1, 8'd1};
        update_en       = 1'b1;
        wait_done(20, "ignored_done_timeout");
        start     = 1'b0;
        update_en = 1'b0;
        @(negedge clk);
        check("ignored_no_restart", 32'(busy), 32'd0);

        // Maximum count on layer 0: rows 0..254, no wrap.
        do_start({8'd0, 8'd0, 8'd255}, 1'b1, k);
        for (int r = 0; r < 255; r++) exp_beat(0, r, 1'b1, k + 3 + r);
        exp_done(k + 258);
        wait_done(300, "max_done_timeout");

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
